// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU write-back path.
//   REG_W / NUM_REGS  - register-file address width and register count
//   WB_DATA_W         - default result width
//   ARB_RR / ARB_FIXED- arbitration mode selectors for cpu_wb_merge
//   wb_entry_t        - one buffered result {dest, data} at the default width
//   reg_onehot()      - one-hot register mask; r0 never marks busy
package cpu_pkg;

  localparam int REG_W     = 5;
  localparam int NUM_REGS  = 32;
  localparam int WB_DATA_W = 32;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef struct packed {
    logic [REG_W-1:0]     dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    m[0] = 1'b0;  // r0 is hard-wired, never pending
    return m;
  endfunction

endpackage

// File: rtl/cpu_wb_fifo.sv
// cpu_wb_fifo: per-source result FIFO for the write-back merge unit.
//   clock, reset     - rising-edge clock, async active-low reset
//   push/push_dest/push_data - write request (caller filters dest=0)
//   pop              - remove head (only honoured when non-empty)
//   head_dest/head_data - current head entry
//   empty, full      - derived from the registered count
//   overflow         - sticky: push while full with no same-cycle pop
//   busy_mask        - OR of one-hot(dest) over all live entries
module cpu_wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic [REG_W-1:0]    push_dest,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  output logic [REG_W-1:0]    head_dest,
  output logic [DATA_W-1:0]   head_data,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign head_dest = mem[rd_ptr].dest;
  assign head_data = mem[rd_ptr].data;

  // NOTE: storage has no reset; validity is tracked by count, so stale
  // contents are never observed and the array maps onto plain RAM/flops.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= '{dest: push_dest, data: push_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Slot k is live when its distance from the read pointer is below count.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin : busy_tree
    logic [PTR_W-1:0] offset;
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      offset = PTR_W'(k) - rd_ptr;
      if (CNT_W'(offset) < count) busy_mask |= reg_onehot(mem[k].dest);
    end
  end

endmodule

// File: rtl/cpu_wb_merge.sv
// cpu_wb_merge: merges results from NUM_SRC latent producers into the single
// register-file write port, one result per free write-back slot.
//   clock, reset  - rising-edge clock, async active-low reset
//   src_valid     - per-source result strobe
//   src_dest      - per-source destination register, slice i = [5i+4:5i]
//   src_data      - per-source result data, slice i
//   src_full      - FIFO i holds DEPTH entries
//   wb_slot       - write-back slot free this cycle
//   wb_valid / wb_dest_reg / wb_data - registered result, zeroed when idle
//   busy_regs     - registers targeted by any buffered or presented result
//   overflow      - sticky per-source overflow flags
module cpu_wb_merge
  import cpu_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*REG_W-1:0]   src_dest,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]         src_full,
  input  logic                       wb_slot,
  output logic                       wb_valid,
  output logic [REG_W-1:0]           wb_dest_reg,
  output logic [DATA_W-1:0]          wb_data,
  output logic [NUM_REGS-1:0]        busy_regs,
  output logic [NUM_SRC-1:0]         overflow
);

  localparam int LG_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam bit USE_FIXED = (FIXED_PRIO == ARB_FIXED);

  logic [NUM_SRC-1:0]  empty;
  logic [NUM_SRC-1:0]  pop;
  logic [REG_W-1:0]    head_dest [NUM_SRC];
  logic [DATA_W-1:0]   head_data [NUM_SRC];
  logic [NUM_REGS-1:0] fifo_mask [NUM_SRC];

  logic                grant;
  logic [LG_W-1:0]     grant_idx;
  logic [LG_W-1:0]     last_grant;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic push;
    // dest=0 results have no architectural effect and are dropped here.
    assign push = src_valid[g] && (src_dest[g*REG_W +: REG_W] != '0);

    cpu_wb_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_dest (src_dest[g*REG_W +: REG_W]),
      .push_data (src_data[g*DATA_W +: DATA_W]),
      .pop       (pop[g]),
      .head_dest (head_dest[g]),
      .head_data (head_data[g]),
      .empty     (empty[g]),
      .full      (src_full[g]),
      .overflow  (overflow[g]),
      .busy_mask (fifo_mask[g])
    );
  end

  // Round-robin visits last_grant+1 .. last_grant+NUM_SRC; fixed priority
  // visits 0 .. NUM_SRC-1. The first non-empty candidate wins.
  always_comb begin : arbiter
    int idx;
    grant     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = USE_FIXED ? k : (int'(last_grant) + 1 + k) % NUM_SRC;
      if (!grant && wb_slot && !empty[idx]) begin
        grant     = 1'b1;
        grant_idx = LG_W'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid    <= 1'b0;
      wb_dest_reg <= '0;
      wb_data     <= '0;
      last_grant  <= LG_W'(NUM_SRC - 1);
    end else if (grant) begin
      wb_valid    <= 1'b1;
      wb_dest_reg <= head_dest[grant_idx];
      wb_data     <= head_data[grant_idx];
      last_grant  <= grant_idx;
    end else begin
      // Idle slots clear the register so each result is shown exactly once.
      wb_valid    <= 1'b0;
      wb_dest_reg <= '0;
      wb_data     <= '0;
    end
  end

  always_comb begin
    busy_regs = wb_valid ? reg_onehot(wb_dest_reg) : '0;
    for (int g = 0; g < NUM_SRC; g++) busy_regs |= fifo_mask[g];
    busy_regs[0] = 1'b0;
  end

endmodule

// File: tb/tb_cpu_wb_merge.sv
module tb_cpu_wb_merge;
  import cpu_pkg::*;

  localparam int NS = 3;
  localparam int DP = 4;
  localparam int DW = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [NS-1:0]  src_valid = '0;
  logic [NS*5-1:0]  src_dest = '0;
  logic [NS*DW-1:0] src_data = '0;
  logic           wb_slot = 1'b0;

  logic [NS-1:0]  rr_full, rr_ovf, fp_full, fp_ovf;
  logic           rr_v, fp_v;
  logic [4:0]     rr_dest, fp_dest;
  logic [DW-1:0]  rr_data, fp_data;
  logic [31:0]    rr_busy, fp_busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clock = ~clock;

  cpu_wb_merge #(.NUM_SRC(NS), .DEPTH(DP), .DATA_W(DW), .FIXED_PRIO(ARB_RR)) u_rr (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_dest(src_dest),
    .src_data(src_data), .src_full(rr_full), .wb_slot(wb_slot), .wb_valid(rr_v),
    .wb_dest_reg(rr_dest), .wb_data(rr_data), .busy_regs(rr_busy), .overflow(rr_ovf));

  cpu_wb_merge #(.NUM_SRC(NS), .DEPTH(DP), .DATA_W(DW), .FIXED_PRIO(ARB_FIXED)) u_fp (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_dest(src_dest),
    .src_data(src_data), .src_full(fp_full), .wb_slot(wb_slot), .wb_valid(fp_v),
    .wb_dest_reg(fp_dest), .wb_data(fp_data), .busy_regs(fp_busy), .overflow(fp_ovf));

  // ---------------- reference model: one queue per source per instance ----
  // Instance 0 is round-robin, instance 1 is fixed priority.
  wb_entry_t   mq [2*NS][$];
  int          m_lg   [2];
  logic        m_v    [2];
  logic [4:0]  m_dest [2];
  logic [31:0] m_data [2];
  logic [NS-1:0] m_ovf [2];

  task automatic model_reset();
    for (int q = 0; q < 2*NS; q++) mq[q].delete();
    for (int m = 0; m < 2; m++) begin
      m_lg[m] = NS - 1; m_v[m] = 0; m_dest[m] = 0; m_data[m] = 0; m_ovf[m] = '0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int win;
      wb_entry_t e;
      win = -1;
      if (wb_slot) begin
        for (int k = 0; k < NS; k++) begin
          int s;
          s = (m == 1) ? k : (m_lg[m] + 1 + k) % NS;
          if (win < 0 && mq[m*NS+s].size() > 0) win = s;
        end
      end
      if (win >= 0) begin
        e = mq[m*NS+win].pop_front();
        m_v[m] = 1; m_dest[m] = e.dest; m_data[m] = e.data; m_lg[m] = win;
      end else begin
        m_v[m] = 0; m_dest[m] = 0; m_data[m] = 0;
      end
      for (int s = 0; s < NS; s++) begin
        if (src_valid[s] && src_dest[s*5 +: 5] != 0) begin
          if (mq[m*NS+s].size() < DP) begin
            e.dest = src_dest[s*5 +: 5];
            e.data = src_data[s*DW +: DW];
            mq[m*NS+s].push_back(e);
          end else begin
            m_ovf[m][s] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [NS-1:0] model_full(int m);
    logic [NS-1:0] f;
    for (int s = 0; s < NS; s++) f[s] = (mq[m*NS+s].size() == DP);
    return f;
  endfunction

  function automatic logic [31:0] model_busy(int m);
    logic [31:0] b;
    b = '0;
    for (int s = 0; s < NS; s++)
      foreach (mq[m*NS+s][j]) b[mq[m*NS+s][j].dest] = 1'b1;
    if (m_v[m]) b[m_dest[m]] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input int m, input string name, input logic v, input logic [4:0] d,
                           input logic [31:0] x, input logic [NS-1:0] f, input logic [NS-1:0] o,
                           input logic [31:0] busy);
    check_val({name, ".wb_valid"}, 32'(v), 32'(m_v[m]));
    check_val({name, ".wb_dest_reg"}, 32'(d), 32'(m_dest[m]));
    check_val({name, ".wb_data"}, x, m_data[m]);
    check_val({name, ".src_full"}, 32'(f), 32'(model_full(m)));
    check_val({name, ".overflow"}, 32'(o), 32'(m_ovf[m]));
    check_val({name, ".busy_regs"}, busy, model_busy(m));
  endtask

  task automatic check_both();
    check_dut(0, "rr", rr_v, rr_dest, rr_data, rr_full, rr_ovf, rr_busy);
    check_dut(1, "fp", fp_v, fp_dest, fp_data, fp_full, fp_ovf, fp_busy);
  endtask

  // Advance one edge, update the model, sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step();
    cyc++;
    #1;
    check_both();
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic reset_pulse();
    reset = 1'b0;
    model_reset();
    #1;
    check_both();
    check_val("rst.wb_valid_now", 32'(rr_v), 32'd0);
    check_val("rst.busy_now", rr_busy, 32'd0);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive(input int s, input logic v, input logic [4:0] d, input logic [31:0] x);
    src_valid[s]        = v;
    src_dest[s*5 +: 5]  = d;
    src_data[s*DW +: DW] = x;
  endtask

  task automatic idle_all();
    for (int s = 0; s < NS; s++) drive(s, 1'b0, 5'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_rr [6];
    int exp_fp [6];
    logic [31:0] saved_busy;
    logic [NS-1:0] mf;
    exp_rr = '{10, 12, 14, 11, 13, 15};
    exp_fp = '{10, 11, 12, 13, 14, 15};

    // Reset state
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_both();
    reset = 1'b1;

    // Single push: latency of two edges, one-cycle presentation
    wb_slot = 1'b1;
    drive(0, 1'b1, 5'd5, 32'h12345678);
    tick();
    check_val("single.valid_e1", 32'(rr_v), 32'd0);
    check_val("single.busy5_e1", 32'(rr_busy[5]), 32'd1);
    idle_all();
    tick();
    check_val("single.valid_e2", 32'(rr_v), 32'd1);
    check_val("single.dest_e2", 32'(rr_dest), 32'd5);
    check_val("single.data_e2", rr_data, 32'h12345678);
    check_val("single.busy5_e2", 32'(rr_busy[5]), 32'd1);
    tick();
    check_val("single.valid_e3", 32'(rr_v), 32'd0);
    check_val("single.busy5_e3", 32'(rr_busy[5]), 32'd0);

    // Arbitration order with two entries preloaded per source
    reset_pulse();
    wb_slot = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < NS; s++) drive(s, 1'b1, 5'(10 + 2*s + k), 32'(100 + 10*s + k));
      tick();
    end
    idle_all();
    wb_slot = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val($sformatf("rr.order%0d", i), 32'(rr_dest), 32'(exp_rr[i]));
      check_val($sformatf("fp.order%0d", i), 32'(fp_dest), 32'(exp_fp[i]));
    end
    tick();

    // Full and overflow on source 1
    reset_pulse();
    wb_slot = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 5'(20 + i), 32'(i));
      tick();
    end
    check_val("ovf.full_after4", 32'(rr_full[1]), 32'd1);
    drive(1, 1'b1, 5'd25, 32'hdead);
    tick();
    check_val("ovf.flag_set", 32'(rr_ovf[1]), 32'd1);
    check_val("ovf.busy25_dropped", 32'(rr_busy[25]), 32'd0);
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 5'(20 + i), 32'(i));
      tick();
    end
    drive(1, 1'b1, 5'd26, 32'hbeef);
    wb_slot = 1'b1;
    tick();
    check_val("ovf.pushpop_clear", 32'(rr_ovf[1]), 32'd0);
    check_val("ovf.pushpop_full", 32'(rr_full[1]), 32'd1);
    check_val("ovf.pushpop_busy26", 32'(rr_busy[26]), 32'd1);
    idle_all();
    wb_slot = 1'b0;
    tick();

    // dest=0 is discarded; stall holds state
    reset_pulse();
    wb_slot = 1'b1;
    drive(0, 1'b1, 5'd0, 32'h5555);
    tick();
    idle_all();
    check_val("dest0.busy", rr_busy, 32'd0);
    tick();
    check_val("dest0.no_output", 32'(rr_v), 32'd0);
    wb_slot = 1'b0;
    drive(0, 1'b1, 5'd7, 32'h7);
    drive(2, 1'b1, 5'd9, 32'h9);
    tick();
    idle_all();
    saved_busy = rr_busy;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("stall.valid", 32'(rr_v), 32'd0);
      check_val("stall.busy_hold", rr_busy, saved_busy);
    end

    // Reset in the middle of activity
    reset_pulse();
    wb_slot = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2, 1'b1, 5'(3 + i), 32'(1000 + i));
      tick();
    end
    idle_all();
    wb_slot = 1'b1;
    tick();
    check_val("midrst.valid_before", 32'(rr_v), 32'd1);
    reset_pulse();
    check_val("midrst.dest_now", 32'(rr_dest), 32'd0);
    check_val("midrst.data_now", rr_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("midrst.no_stale", 32'(rr_v), 32'd0);
    end

    // Randomised traffic; sources mostly respect src_full
    reset_pulse();
    for (int c = 0; c < 400; c++) begin
      wb_slot = ($urandom_range(0, 3) != 0);
      mf = model_full(0) | model_full(1);
      for (int s = 0; s < NS; s++) begin
        logic want;
        want = ($urandom_range(0, 2) == 0);
        if (mf[s] && $urandom_range(0, 15) != 0) want = 1'b0;
        drive(s, want, 5'($urandom_range(0, 31)), $urandom);
      end
      tick();
    end
    idle_all();
    wb_slot = 1'b1;
    repeat (16) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_wb_merge.md
# cpu_wb_merge

Parametrised write-back merge unit: collects results from `NUM_SRC` latent producers (data-cache read return, divider, and future long-latency units), buffers each in its own FIFO, and inserts one result per free write-back slot into the CPU register-file write port. It generalises the two-source read-return path to N sources with configurable depth and arbitration mode. It adds per-source back-pressure, overflow detection and a pending-destination scoreboard for the decoder.

## Interface
Parameters:
- `NUM_SRC`, 2: number of producer channels, 1..8.
- `DEPTH`, 4: entries per source FIFO, power of two, ≥2.
- `DATA_W`, 32: result width.
- `FIXED_PRIO`, 0: 0 = round-robin arbitration; 1 = fixed priority, lowest index wins.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 forces the reset state immediately.
- `src_valid`  in  NUM_SRC  per-source result strobe, one cycle per result.
- `src_dest`  in  NUM_SRC*5  destination register per source; source i occupies bits [5i+4:5i].
- `src_data`  in  NUM_SRC*DATA_W  result data per source, slice i.
- `src_full`  out  NUM_SRC  registered; high when FIFO i holds DEPTH entries. The source must not strobe while high.
- `wb_slot`  in  1  pipeline write-back slot free this cycle (the decoder's `cpu_ready`).
- `wb_valid`  out  1  registered; a result is presented this cycle.
- `wb_dest_reg`  out  5  registered; destination register, 0 when `wb_valid`=0.
- `wb_data`  out  DATA_W  registered; result data, 0 when `wb_valid`=0.
- `busy_regs`  out  32  combinational; bit r set if any FIFO entry or the output register targets register r. Bit 0 is always 0.
- `overflow`  out  NUM_SRC  sticky; set when source i strobes into a full FIFO without a same-cycle pop.

## Operation
- Push: `src_valid[i]`=1 with `src_dest` slice ≠0 writes {dest, data} into FIFO i at the clock edge.
  - dest=0 results are discarded and never pushed.
- Full handling for FIFO i:
  - Push with `src_full[i]`=1 and no pop of FIFO i in the same cycle: entry dropped, `overflow[i]` set.
  - Push and pop in the same cycle on a full FIFO: both accepted; count unchanged.
- Arbitration runs each cycle `wb_slot`=1 over the set of non-empty FIFOs:
  - Round-robin: search starts at `last_grant`+1 and wraps modulo NUM_SRC.
  - Fixed priority: lowest non-empty index wins.
  - The winner's head is popped into the output register (`wb_valid`=1).
  - `last_grant` updates only on a grant.
- Any cycle with no grant (`wb_slot`=0 or all FIFOs empty): output register loads valid=0, dest=0, data=0. Each result is therefore presented for exactly one cycle.
- FIFO i: read/write pointers of log2(DEPTH) bits wrapping naturally, plus a count of log2(DEPTH)+1 bits.
  - `src_full[i]` = (count==DEPTH).
- `busy_regs`: OR of one-hot(dest) over all valid FIFO entries plus the output register when `wb_valid`=1.
- Reset values: all FIFOs empty; `src_full`=0; `wb_valid`=0, `wb_dest_reg`=0, `wb_data`=0; `overflow`=0; `last_grant`=NUM_SRC-1, so source 0 is first in round-robin.
- Reset asserted mid-operation discards all buffered results; no partial output is produced.

## Timing
- Push at edge N: entry is visible in the FIFO and in `busy_regs` from cycle N.
- Earliest pop is at edge N+1 if `wb_slot`=1 during cycle N+1-1. `wb_valid` is high the cycle after that edge.
- Minimum latency: 2 edges from `src_valid` to `wb_valid`.
- Throughput: one result per cycle while `wb_slot`=1.
- `src_full` reflects the count after the current edge. A source sampling it combinationally in the same cycle avoids overflow.
- `busy_regs` is combinational from registered state only; no input-to-output combinational path.

## Structure
- Shared package `cpu_pkg` holds:
  - `REG_W`=5, `NUM_REGS`=32.
  - typedef `wb_entry_t` {dest[4:0], data[DATA_W-1:0]}.
  - `ARB_RR`/`ARB_FIXED` constants.
- Sub-module `cpu_wb_fifo`: single-source FIFO with push/pop, count, full/empty, overflow flag, and an entries-as-onehot-mask output. It is instantiated NUM_SRC times via generate.
- Arbiter, output register and `busy_regs` OR-tree live in `cpu_wb_merge`.

## Test plan
- Reset, then single push: source 0 pushes dest=5, data=0x12345678 with `wb_slot`=1. Expect `wb_valid`=1, dest 5, data 0x12345678 exactly 2 edges later for one cycle; `busy_regs[5]`=1 until `wb_valid` drops.
- Round-robin fairness: NUM_SRC=3, all FIFOs preloaded with 2 entries, `wb_slot`=1 continuously. Expect grant order 0,1,2,0,1,2; with FIXED_PRIO=1 expect 0,0,1,1,2,2.
- Full and overflow: DEPTH=4, `wb_slot`=0, 4 pushes on source 1 gives `src_full[1]`=1. A 5th push sets `overflow[1]` and the count stays 4. A push together with a pop when full is accepted and `overflow` stays clear.
- Dest 0 and stall: push dest=0 is ignored (FIFO stays empty). With `wb_slot` held 0 for 10 cycles, no output is produced and `busy_regs` holds its value.
- Reset mid-operation: with 3 entries buffered and `wb_valid`=1, pulse `reset` low asynchronously between edges. All outputs are 0 immediately; after release, no stale result appears.
